// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional build macro IF_ALIGN_CHK_EN is consumed by if_stage and if_npc_sel.
package if_stage_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int          INST_ADDR_W = 32;
    localparam int          STALL_BUS_W = 4;
    localparam logic [31:0] PC_INIT     = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_WAIT  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC priority mux: exception > jump > pending jump > sequential.
// Without IF_ALIGN_CHK_EN every redirect target is forced to word alignment.
module if_npc_sel
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              i_exc_flag,
    input  logic [ADDR_W-1:0] i_exc_addr,
    input  logic              i_jump_flag,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_pend,
    input  logic [ADDR_W-1:0] i_pend_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_npc,
    output logic [ADDR_W-1:0] o_jump_tgt,
    output logic              o_use_pend
);

    logic [ADDR_W-1:0] w_exc_tgt;

`ifdef IF_ALIGN_CHK_EN
    assign w_exc_tgt  = i_exc_addr;
    assign o_jump_tgt = i_jump_addr;
`else
    logic w_unused_low;
    assign w_unused_low = ^{i_exc_addr[1:0], i_jump_addr[1:0]};
    assign w_exc_tgt    = {i_exc_addr[ADDR_W-1:2], 2'b00};
    assign o_jump_tgt   = {i_jump_addr[ADDR_W-1:2], 2'b00};
`endif

    always_comb begin
        o_npc      = i_pc + ADDR_W'(4);
        o_use_pend = 1'b0;
        if (i_exc_flag) begin
            o_npc = w_exc_tgt;
        end else if (i_jump_flag) begin
            o_npc = o_jump_tgt;
        end else if (i_pend) begin
            o_npc      = i_pend_addr;
            o_use_pend = 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch handshake FSM and deferred redirects.
// Define IF_ALIGN_CHK_EN to add misaligned-fetch detection (if_exc_adel / if_badvaddr).
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                STALL_W  = STALL_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = PC_INIT
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               jump_flag,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               exc_flag,
    input  logic [ADDR_W-1:0]  exc_addr,
    input  logic               iack,
    output logic               ice,
    output logic [ADDR_W-1:0]  iaddr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_kill,
    output logic               stallreq_if
`ifdef IF_ALIGN_CHK_EN
   ,output logic               if_exc_adel,
    output logic [ADDR_W-1:0]  if_badvaddr
`endif
);

    if_state_e         r_state;
    if_state_e         w_state_nx;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nx;
    logic              r_pend;
    logic              w_pend_nx;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [ADDR_W-1:0] w_pend_addr_nx;
    logic              r_drop;
    logic              w_drop_nx;

    logic              w_ice;
    logic              w_adv;
    logic [ADDR_W-1:0] w_npc;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic              w_use_pend;
    logic              w_unused_stall;

    assign w_unused_stall = ^stall[STALL_W-1:1];

`ifdef IF_ALIGN_CHK_EN
    logic w_misalign;
    assign w_misalign  = (r_pc[1:0] != 2'b00);
    assign w_ice       = (r_state != IF_IDLE) && !w_misalign;
    assign if_exc_adel = w_misalign;
    assign if_badvaddr = r_pc;
`else
    assign w_ice = (r_state != IF_IDLE);
`endif

    // r_drop marks an iack that still belongs to a request abandoned by an exception.
    assign w_adv       = w_ice && iack && !r_drop && (stall[0] == NOSTOP);
    assign ice         = w_ice;
    assign iaddr       = r_pc;
    assign if_pc       = r_pc;
    assign stallreq_if = w_ice && !iack;
    assign if_kill     = exc_flag || (w_adv && w_use_pend);

    if_npc_sel #(
        .ADDR_W (ADDR_W)
    ) u_npc_sel (
        .i_exc_flag  (exc_flag),
        .i_exc_addr  (exc_addr),
        .i_jump_flag (jump_flag),
        .i_jump_addr (jump_addr),
        .i_pend      (r_pend),
        .i_pend_addr (r_pend_addr),
        .i_pc        (r_pc),
        .o_npc       (w_npc),
        .o_jump_tgt  (w_jump_tgt),
        .o_use_pend  (w_use_pend)
    );

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= IF_IDLE;
            r_pc        <= RESET_PC;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_pend      <= w_pend_nx;
            r_pend_addr <= w_pend_addr_nx;
            r_drop      <= w_drop_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_pend_nx      = r_pend;
        w_pend_addr_nx = r_pend_addr;
        w_drop_nx      = r_drop;

        case (r_state)
            IF_IDLE:  w_state_nx = IF_FETCH;
            IF_FETCH: if (!iack) w_state_nx = IF_WAIT;
            IF_WAIT:  if (iack)  w_state_nx = IF_FETCH;
            default:  w_state_nx = IF_IDLE;
        endcase

        if (iack) begin
            w_drop_nx = 1'b0;
        end

        if (exc_flag) begin
            w_state_nx = IF_FETCH;
            w_pc_nx    = w_npc;
            w_pend_nx  = 1'b0;
            w_drop_nx  = w_ice && !iack;
        end else if (w_adv) begin
            w_pc_nx   = w_npc;
            w_pend_nx = 1'b0;
        end else if (jump_flag) begin
            w_pend_nx      = 1'b1;
            w_pend_addr_nx = w_jump_tgt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a behavioural fetch model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk;
    logic        rstN;
    logic [3:0]  stall;
    logic        jumpFlag;
    logic [31:0] jumpAddr;
    logic        excFlag;
    logic [31:0] excAddr;
    logic        iack;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] ifPc;
    logic        ifKill;
    logic        stallreqIf;
`ifdef IF_ALIGN_CHK_EN
    logic        ifExcAdel;
    logic [31:0] ifBadvaddr;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model: fetching has begun, PC, deferred jump, abandoned request.
    logic        mStarted;
    logic [31:0] mPc;
    logic        mPend;
    logic [31:0] mPendAddr;
    logic        mDrop;

    if_stage dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rstN),
        .stall       (stall),
        .jump_flag   (jumpFlag),
        .jump_addr   (jumpAddr),
        .exc_flag    (excFlag),
        .exc_addr    (excAddr),
        .iack        (iack),
        .ice         (ice),
        .iaddr       (iaddr),
        .if_pc       (ifPc),
        .if_kill     (ifKill),
        .stallreq_if (stallreqIf)
`ifdef IF_ALIGN_CHK_EN
       ,.if_exc_adel (ifExcAdel),
        .if_badvaddr (ifBadvaddr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IF_ALIGN_CHK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic expIce();
`ifdef IF_ALIGN_CHK_EN
        return mStarted && (mPc % 4 == 0);
`else
        return mStarted;
`endif
    endfunction

    function automatic logic expAdv();
        return expIce() && iack && !mDrop && !stall[0];
    endfunction

    function automatic logic expKill();
        return excFlag || (expAdv() && !jumpFlag && mPend);
    endfunction

    task automatic modelReset();
        mStarted  = 1'b0;
        mPc       = 32'h0;
        mPend     = 1'b0;
        mPendAddr = 32'h0;
        mDrop     = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        logic        nStarted;
        logic [31:0] nPc;
        logic        nPend;
        logic [31:0] nPendAddr;
        logic        nDrop;
        nStarted  = 1'b1;
        nPc       = mPc;
        nPend     = mPend;
        nPendAddr = mPendAddr;
        nDrop     = iack ? 1'b0 : mDrop;
        if (excFlag) begin
            nPc   = tgt(excAddr);
            nPend = 1'b0;
            nDrop = expIce() && !iack;
        end else if (expAdv()) begin
            if (jumpFlag)   nPc = tgt(jumpAddr);
            else if (mPend) nPc = mPendAddr;
            else            nPc = mPc + 32'd4;
            nPend = 1'b0;
        end else if (jumpFlag) begin
            nPend     = 1'b1;
            nPendAddr = tgt(jumpAddr);
        end
        @(posedge clk);
        #1;
        mStarted  = nStarted;
        mPc       = nPc;
        mPend     = nPend;
        mPendAddr = nPendAddr;
        mDrop     = nDrop;
    endtask

    task automatic clearInputs();
        stall    = 4'b0;
        jumpFlag = 1'b0;
        jumpAddr = 32'h0;
        excFlag  = 1'b0;
        excAddr  = 32'h0;
        iack     = 1'b0;
    endtask

    // Leaves the DUT in its idle cycle, just after reset release.
    task automatic doReset();
        clearInputs();
        rstN = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        clearInputs();
        rstN = 1'b0;
        modelReset();
        #3;
        checks++; if (ice !== 1'b0) begin failures++; $display("[TB] FAIL reset_ice got=%b exp=0", ice); end
        checks++; if (iaddr !== 32'h0) begin failures++; $display("[TB] FAIL reset_iaddr got=%h exp=00000000", iaddr); end
        checks++; if (ifKill !== 1'b0) begin failures++; $display("[TB] FAIL reset_kill got=%b exp=0", ifKill); end
        checks++; if (stallreqIf !== 1'b0) begin failures++; $display("[TB] FAIL reset_stallreq got=%b exp=0", stallreqIf); end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        #1;
        checks++; if (ice !== 1'b0) begin failures++; $display("[TB] FAIL idle_ice got=%b exp=0", ice); end
    endtask

    task automatic test_sequential();
        doReset();
        iack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (iaddr !== 32'(i * 4)) begin failures++; $display("[TB] FAIL seq_iaddr[%0d] got=%h exp=%h", i, iaddr, 32'(i * 4)); end
            checks++; if (ifPc !== 32'(i * 4)) begin failures++; $display("[TB] FAIL seq_ifpc[%0d] got=%h exp=%h", i, ifPc, 32'(i * 4)); end
            checks++; if (ice !== 1'b1 || ifKill !== 1'b0) begin failures++; $display("[TB] FAIL seq_ctl[%0d] got ice=%b kill=%b exp ice=1 kill=0", i, ice, ifKill); end
            tick();
        end
    endtask

    task automatic test_wait();
        doReset();
        iack = 1'b1;
        repeat (3) tick();
        iack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (iaddr !== 32'h8) begin failures++; $display("[TB] FAIL wait_iaddr[%0d] got=%h exp=00000008", i, iaddr); end
            checks++; if (stallreqIf !== 1'b1) begin failures++; $display("[TB] FAIL wait_stallreq[%0d] got=%b exp=1", i, stallreqIf); end
            tick();
        end
        iack = 1'b1;
        #1;
        checks++; if (stallreqIf !== 1'b0) begin failures++; $display("[TB] FAIL wait_release got=%b exp=0", stallreqIf); end
        tick();
        #1;
        checks++; if (iaddr !== 32'hC) begin failures++; $display("[TB] FAIL wait_next got=%h exp=0000000c", iaddr); end
    endtask

    task automatic test_jump_pending();
        doReset();
        iack = 1'b1;
        repeat (3) tick();
        iack = 1'b0;
        tick();
        jumpFlag = 1'b1;
        jumpAddr = 32'h100;
        #1;
        checks++; if (ifKill !== 1'b0) begin failures++; $display("[TB] FAIL jmp_nokill got=%b exp=0", ifKill); end
        tick();
        jumpFlag = 1'b0;
        iack     = 1'b1;
        #1;
        checks++; if (ifKill !== 1'b1) begin failures++; $display("[TB] FAIL jmp_kill got=%b exp=1", ifKill); end
        checks++; if (iaddr !== 32'h8) begin failures++; $display("[TB] FAIL jmp_hold got=%h exp=00000008", iaddr); end
        tick();
        #1;
        checks++; if (iaddr !== 32'h100) begin failures++; $display("[TB] FAIL jmp_target got=%h exp=00000100", iaddr); end
        checks++; if (ifKill !== 1'b0) begin failures++; $display("[TB] FAIL jmp_pulse got=%b exp=0", ifKill); end
    endtask

    task automatic test_exc_stall();
        doReset();
        iack = 1'b1;
        repeat (2) tick();
        stall    = 4'b0001;
        jumpFlag = 1'b1;
        jumpAddr = 32'h200;
        tick();
        jumpFlag = 1'b0;
        #1;
        checks++; if (iaddr !== 32'h4) begin failures++; $display("[TB] FAIL stall_hold got=%h exp=00000004", iaddr); end
        excFlag = 1'b1;
        excAddr = 32'h380;
        #1;
        checks++; if (ifKill !== 1'b1) begin failures++; $display("[TB] FAIL exc_kill got=%b exp=1", ifKill); end
        tick();
        excFlag = 1'b0;
        #1;
        checks++; if (iaddr !== 32'h380) begin failures++; $display("[TB] FAIL exc_pc got=%h exp=00000380", iaddr); end
        stall = 4'b0000;
        #1;
        checks++; if (ifKill !== 1'b0) begin failures++; $display("[TB] FAIL exc_pend_cleared got=%b exp=0", ifKill); end
        tick();
        #1;
        checks++; if (iaddr !== 32'h384) begin failures++; $display("[TB] FAIL exc_seq got=%h exp=00000384", iaddr); end
    endtask

    task automatic test_async_reset();
        doReset();
        iack = 1'b1;
        repeat (3) tick();
        iack = 1'b0;
        tick();
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checks++; if (ice !== 1'b0) begin failures++; $display("[TB] FAIL areset_ice got=%b exp=0", ice); end
        checks++; if (iaddr !== 32'h0) begin failures++; $display("[TB] FAIL areset_pc got=%h exp=00000000", iaddr); end
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_wrap_align();
        doReset();
        iack = 1'b1;
        tick();
        excFlag = 1'b1;
        excAddr = 32'hFFFF_FFFC;
        tick();
        excFlag = 1'b0;
        #1;
        checks++; if (iaddr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_pre got=%h exp=fffffffc", iaddr); end
        tick();
        #1;
        checks++; if (iaddr !== 32'h0) begin failures++; $display("[TB] FAIL wrap got=%h exp=00000000", iaddr); end
        jumpFlag = 1'b1;
        jumpAddr = 32'h102;
        tick();
        jumpFlag = 1'b0;
        #1;
`ifdef IF_ALIGN_CHK_EN
        checks++; if (ice !== 1'b0 || ifExcAdel !== 1'b1) begin failures++; $display("[TB] FAIL adel got ice=%b adel=%b exp ice=0 adel=1", ice, ifExcAdel); end
        checks++; if (ifBadvaddr !== 32'h102) begin failures++; $display("[TB] FAIL badvaddr got=%h exp=00000102", ifBadvaddr); end
        tick();
        #1;
        checks++; if (iaddr !== 32'h102) begin failures++; $display("[TB] FAIL adel_hold got=%h exp=00000102", iaddr); end
        excFlag = 1'b1;
        excAddr = 32'h180;
        tick();
        excFlag = 1'b0;
        #1;
        checks++; if (iaddr !== 32'h180 || ice !== 1'b1) begin failures++; $display("[TB] FAIL adel_recover got pc=%h ice=%b exp pc=00000180 ice=1", iaddr, ice); end
`else
        checks++; if (iaddr !== 32'h100) begin failures++; $display("[TB] FAIL align_force got=%h exp=00000100", iaddr); end
        checks++; if (ice !== 1'b1) begin failures++; $display("[TB] FAIL align_ice got=%b exp=1", ice); end
`endif
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 600; c++) begin
            iack     = ($urandom_range(0, 3) != 0);
            stall    = 4'($urandom_range(0, 15));
            stall[0] = ($urandom_range(0, 4) == 0);
            jumpFlag = ($urandom_range(0, 5) == 0);
            jumpAddr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) jumpAddr = jumpAddr | 32'($urandom_range(1, 3));
            excFlag  = ($urandom_range(0, 24) == 0);
            excAddr  = $urandom & 32'hFFFF_FFFC;
            #1;
            checks++; if (iaddr !== mPc || ifPc !== mPc) begin failures++; $display("[TB] FAIL rnd_pc[%0d] got iaddr=%h if_pc=%h exp=%h", c, iaddr, ifPc, mPc); end
            checks++; if (ice !== expIce()) begin failures++; $display("[TB] FAIL rnd_ice[%0d] got=%b exp=%b", c, ice, expIce()); end
            checks++; if (ifKill !== expKill()) begin failures++; $display("[TB] FAIL rnd_kill[%0d] got=%b exp=%b", c, ifKill, expKill()); end
            checks++; if (stallreqIf !== (expIce() && !iack)) begin failures++; $display("[TB] FAIL rnd_stallreq[%0d] got=%b exp=%b", c, stallreqIf, expIce() && !iack); end
            tick();
        end
    endtask

    initial begin
        clearInputs();
        rstN = 1'b0;
        modelReset();
        test_reset();
        test_sequential();
        test_wait();
        test_jump_pending();
        test_exc_stall();
        test_async_reset();
        test_wrap_align();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
